// File: rtl/line_clear_engine.sv
// Row-clear engine for the falling-block board.
// Takes one snapshot per locked piece and scans it for full rows. Full rows
// flash for FLASH_TICKS frame ticks. The board is then collapsed downward one
// destination row per cycle, written back, and a saturating score is updated.
module line_clear_engine #(
  parameter int ROWS        = 20,
  parameter int COLS        = 12,
  parameter int FLASH_TICKS = 30,
  parameter int SCORE_W     = 7,
  parameter int SCORE_MAX   = 99,
  parameter int SCORE_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         tick,
  input  logic [ROWS*COLS-1:0]         board_in,
  output logic [ROWS*COLS-1:0]         board_out,
  output logic                         board_we,
  output logic [ROWS*COLS-1:0]         flash,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(ROWS+1)-1:0]    lines_cleared,
  output logic [SCORE_W-1:0]           score
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS + 1);
  localparam int TW = $clog2(FLASH_TICKS + 1);
  localparam int SW = SCORE_W + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FLASH,
    S_COLLAPSE,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]       r_snap;
  logic [N-1:0]       r_col;
  logic [N-1:0]       r_bout;
  logic [ROWS-1:0]    r_mask;
  logic [LW-1:0]      r_cnt;
  logic [LW-1:0]      r_lines;
  logic [SCORE_W-1:0] r_score;
  logic [PW-1:0]      r_row;
  logic [PW-1:0]      r_dst;
  logic [PW-1:0]      r_src;
  logic               r_src_vld;
  logic [TW-1:0]      r_tcnt;

  logic               w_row_full;
  logic [LW-1:0]      w_cnt_inc;
  logic               w_last_row;
  logic               w_tick_last;
  logic               w_dst_last;
  logic               w_found;
  logic [PW-1:0]      w_sel;
  logic [COLS-1:0]    w_src_row;
  logic [N-1:0]       w_col_next;

  // Points awarded for one operation clearing n rows.
  function automatic logic [SW-1:0] points_f(input logic [LW-1:0] n);
    if (SCORE_MODE == 0) begin
      return SW'(n);
    end
    if (n == LW'(0)) return SW'(0);
    if (n == LW'(1)) return SW'(1);
    if (n == LW'(2)) return SW'(3);
    if (n == LW'(3)) return SW'(5);
    return SW'(8);
  endfunction

  // Widened add clamped at SCORE_MAX; the extra bits keep the sum from wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [SW-1:0]      p);
    logic [SW-1:0] sum;
    sum = SW'(s) + p;
    if (sum > SW'(SCORE_MAX)) return SCORE_W'(SCORE_MAX);
    return sum[SCORE_W-1:0];
  endfunction

  assign w_row_full  = &r_snap[r_row*COLS +: COLS];
  assign w_cnt_inc   = r_cnt + LW'(w_row_full);
  assign w_last_row  = (r_row == PW'(ROWS - 1));
  assign w_tick_last = tick && (r_tcnt == TW'(FLASH_TICKS - 1));
  assign w_dst_last  = (r_dst == '0);

  // Next source row for the collapse: the lowest unmasked row at or above r_src.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!w_found && r_src_vld && (i <= int'(r_src)) && !r_mask[i]) begin
        w_found = 1'b1;
        w_sel   = PW'(i);
      end
    end
  end

  assign w_src_row = w_found ? r_snap[w_sel*COLS +: COLS] : '0;

  // Collapsed board with the current destination row filled in.
  always_comb begin
    w_col_next = r_col;
    w_col_next[r_dst*COLS +: COLS] = w_src_row;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_SCAN;
      S_SCAN:     if (w_last_row) w_next = (w_cnt_inc != '0) ? S_FLASH : S_FINISH;
      S_FLASH:    if (w_tick_last) w_next = S_COLLAPSE;
      S_COLLAPSE: if (w_dst_last) w_next = S_FINISH;
      S_FINISH:   w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Control registers: scan/collapse pointers, mask, counters, results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask    <= '0;
      r_cnt     <= '0;
      r_lines   <= '0;
      r_score   <= '0;
      r_row     <= '0;
      r_dst     <= '0;
      r_src     <= '0;
      r_src_vld <= 1'b0;
      r_tcnt    <= '0;
      r_bout    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask <= '0;
            r_cnt  <= '0;
            r_row  <= '0;
          end
        end
        S_SCAN: begin
          if (w_row_full) r_mask[r_row] <= 1'b1;
          r_cnt <= w_cnt_inc;
          r_row <= r_row + 1'b1;
          if (w_last_row) begin
            r_tcnt    <= '0;
            r_dst     <= PW'(ROWS - 1);
            r_src     <= PW'(ROWS - 1);
            r_src_vld <= 1'b1;
            if (w_cnt_inc == '0) r_lines <= '0;
          end
        end
        S_FLASH: begin
          if (tick) r_tcnt <= r_tcnt + 1'b1;
        end
        S_COLLAPSE: begin
          r_dst <= r_dst - 1'b1;
          if (w_found && (w_sel != '0)) r_src <= w_sel - 1'b1;
          else                          r_src_vld <= 1'b0;
          if (w_dst_last) begin
            r_bout  <= w_col_next;
            r_lines <= r_cnt;
            r_score <= sat_add(r_score, points_f(r_cnt));
          end
        end
        default: ;
      endcase
    end
  end

  // Board data: snapshot on an accepted start, collapsed rows as they are built.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) r_snap <= board_in;
    if (r_state == S_COLLAPSE)      r_col  <= w_col_next;
  end

  // Flash mask: every cell of each full row while flashing.
  always_comb begin
    flash = '0;
    for (int r = 0; r < ROWS; r++) begin
      flash[r*COLS +: COLS] = {COLS{(r_state == S_FLASH) && r_mask[r]}};
    end
  end

  assign board_out     = r_bout;
  assign board_we      = (r_state == S_FINISH) && (r_cnt != '0);
  assign done          = (r_state == S_FINISH);
  assign busy          = (r_state != S_IDLE);
  assign lines_cleared = r_lines;
  assign score         = r_score;

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Parametrised row-clear engine for the falling-block game board.
- Started once per locked piece; snapshots the board, finds full rows and drives flash masks for a set number of frame ticks.
- Then collapses the board downward, writes it back and updates a saturating score.
- Sits between the game control FSM (start, board source/sink) and the VGA renderer (flash).

Parameters:
- ROWS, 20, board height; row 0 = top, row ROWS-1 = bottom.
- COLS, 12, board width.
- FLASH_TICKS, 30, frame ticks for which cleared rows flash before collapse.
- SCORE_W, 7, score register width.
- SCORE_MAX, 99, saturation value; must be <= 2^SCORE_W-1.
- SCORE_MODE, 0, points per clear. 0: points = lines. 1: points = 1/3/5/8 for 1/2/3/>=4 lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; accepted only in IDLE.
- tick  in  1  one-cycle frame pulse; counted only in FLASH.
- board_in  in  ROWS*COLS  board snapshot; cell (r,c) at bit r*COLS+c; 1 = occupied.
- board_out  out  ROWS*COLS  collapsed board, same layout.
- board_we  out  1  one-cycle pulse: board_out valid, caller must load it.
- flash  out  ROWS*COLS  1 = cell flashing.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of every accepted start.
- lines_cleared  out  clog2(ROWS+1)  full-row count of the last operation.
- score  out  SCORE_W  accumulated score.

Behaviour:
- Reset (rst high at a clk edge): state IDLE. board_out, flash, board_we, done, busy, lines_cleared and score all 0. FLASH counter and pointers cleared. Reset wins over every other input in any state, including mid-operation.
- States: IDLE, SCAN, FLASH, COLLAPSE, FINISH.
- IDLE:
  - start=1 at edge k: board_in copied into internal snapshot, full-row mask cleared, go to SCAN.
  - board_in is ignored after edge k.
- SCAN:
  - Exactly ROWS cycles; one row tested per cycle, row 0 first.
  - Row is full iff all COLS bits = 1. Full rows set mask bits and increment the line counter.
  - After the last row: go to FLASH if count > 0, else go to FINISH.
- FLASH:
  - flash = every cell of every masked row, held constant for the whole state; 0 in all other states.
  - Counts tick pulses. On the FLASH_TICKS-th tick, go to COLLAPSE; flash drops to 0 the next cycle.
- COLLAPSE:
  - Exactly ROWS cycles. Destination pointer runs ROWS-1 down to 0, one row per cycle.
  - Source pointer skips masked rows; the destination gets the next unmasked source row, or all-zero once sources are exhausted.
  - Relative order of unmasked rows is preserved.
- FINISH (one cycle):
  - done=1.
  - lines_cleared = count.
  - If count > 0: board_out = collapsed board, board_we=1, score updates.
  - If count = 0: board_out unchanged, board_we=0, score unchanged.
  - Return to IDLE.
- Latency from the start edge:
  - No clear: done in cycle ROWS+1.
  - Clear: done ROWS+1 cycles after the final FLASH tick, plus the scan and flash time before it.
- Score: score <= min(score + points, SCORE_MAX), computed at SCORE_W+4 bits, no wrap. Never decrements except by reset.
- start while busy: ignored, no queueing. tick outside FLASH: ignored.
- start and tick in the same cycle in IDLE: start accepted, tick ignored.
- All-full board: count = ROWS; board_out becomes all zeros.

Test Plan (ROWS=20, COLS=12, FLASH_TICKS=3, SCORE_MODE=0 unless stated):
1. Reset -> all outputs 0. Hold rst across a start -> busy stays 0.
2. Board with only row 19 = 0x7FE, start -> busy for 20 cycles, then done=1, board_we=0, lines_cleared=0, score=0.
3. Row 19 = 0xFFF, row 18 = 0x00F, start, 3 ticks -> during FLASH, flash bits 228..239 = 1 and all others 0. At FINISH: board_out row 19 = 0x00F, rows 0..18 = 0, board_we=1, lines_cleared=1, score=1.
4. SCORE_MODE=1; rows 10, 15, 17, 19 full; rows 16 = 0x001 and 18 = 0x002 -> board_out row 19 = 0x002, row 18 = 0x001, all other rows 0; lines_cleared=4, score=8.
5. Saturation: score driven to 97, then a 4-line clear -> score=99; a further 1-line clear -> score stays 99.
6. Robustness (each check independent):
   - start pulsed in SCAN -> ignored.
   - Ticks during SCAN -> not counted.
   - rst asserted mid-FLASH -> next cycle IDLE, flash=0, score=0, no done pulse.
